// File: rtl/exmem_pkg.sv
// Shared types and defaults for the execute->memory buffer controller.
// Holds the controller state encoding and the memory-op classification helper.
package exmem_pkg;

    localparam int REG_AW_DEF  = 5;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_WAIT_MEM,
        ST_READY,
        ST_FAULT
    } exmem_state_t;

    function automatic logic is_memop(input logic memwrite, input logic memtoreg);
        return memwrite | memtoreg;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory; expire fires on the last allowed waiting cycle.
// Expire is gated by enable, so an ack on that same cycle (which drops enable) wins.
module mem_wait_timer
    import exmem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_expire = i_enable & (r_count == LIMIT);

endmodule

// File: rtl/exmem_stage_ctrl.sv
// Execute->memory buffer controller: load enable, op validity, memory handshake with
// timeout, load-use stall and taken-branch flush toward the front end.
module exmem_stage_ctrl
    import exmem_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ex_valid,
    output logic              o_ex_ready,
    input  logic              i_ex_regwrite,
    input  logic              i_ex_memwrite,
    input  logic              i_ex_memtoreg,
    input  logic              i_ex_branch,
    input  logic              i_ex_branch_taken,
    input  logic [REG_AW-1:0] i_ex_write_addr,
    input  logic [REG_AW-1:0] i_id_rs_a,
    input  logic [REG_AW-1:0] i_id_rs_b,
    input  logic              i_id_uses_a,
    input  logic              i_id_uses_b,
    output logic              o_id_stall,
    output logic              o_buf_load,
    output logic              o_mem_req,
    input  logic              i_mem_ack,
    output logic              o_wb_valid,
    input  logic              i_wb_ready,
    output logic              o_flush,
    output logic              o_mem_err
);

    exmem_state_t      r_state;
    exmem_state_t      w_next;
    logic              r_flush;
    logic              r_regwrite;
    logic              r_memtoreg;
    logic [REG_AW-1:0] r_waddr;

    logic w_ex_ready;
    logic w_buf_load;
    logic w_expire;
    logic w_waiting;
    logic w_hit;
    logic w_hazard_live;

    assign w_waiting  = (r_state == ST_WAIT_MEM);
    assign w_ex_ready = (r_state == ST_EMPTY) | ((r_state == ST_READY) & i_wb_ready);
    assign w_buf_load = i_ex_valid & w_ex_ready & ~r_flush;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (~w_waiting),
        .i_enable (w_waiting & ~i_mem_ack),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_buf_load) begin
                    w_next = is_memop(i_ex_memwrite, i_ex_memtoreg) ? ST_WAIT_MEM : ST_READY;
                end
            end
            ST_WAIT_MEM: begin
                if (i_mem_ack) begin
                    w_next = ST_READY;
                end else if (w_expire) begin
                    w_next = ST_FAULT;
                end
            end
            ST_READY: begin
                if (w_buf_load) begin
                    w_next = is_memop(i_ex_memwrite, i_ex_memtoreg) ? ST_WAIT_MEM : ST_READY;
                end else if (i_wb_ready) begin
                    w_next = ST_EMPTY;
                end
            end
            ST_FAULT: begin
                w_next = ST_FAULT;
            end
            default: begin
                w_next = ST_EMPTY;
            end
        endcase
    end

    // The buffered op's attributes are captured only when the buffer actually loads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flush    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_waddr    <= '0;
        end else begin
            r_flush <= w_buf_load & i_ex_branch & i_ex_branch_taken;
            if (w_buf_load) begin
                r_regwrite <= i_ex_regwrite;
                r_memtoreg <= i_ex_memtoreg;
                r_waddr    <= i_ex_write_addr;
            end
        end
    end

    // A load stops being a hazard on the cycle writeback consumes it.
    assign w_hazard_live = w_waiting | ((r_state == ST_READY) & ~i_wb_ready);
    assign w_hit = (i_id_uses_a & (i_id_rs_a == r_waddr))
                 | (i_id_uses_b & (i_id_rs_b == r_waddr));

    assign o_id_stall = r_memtoreg & r_regwrite & w_hazard_live & w_hit
                      & (~ZERO_REG | (r_waddr != '0));
    assign o_ex_ready = w_ex_ready;
    assign o_buf_load = w_buf_load;
    assign o_mem_req  = w_waiting;
    assign o_wb_valid = (r_state == ST_READY);
    assign o_flush    = r_flush;
    assign o_mem_err  = (r_state == ST_FAULT);

endmodule

// File: tb/tb_exmem_stage_ctrl.sv
// Self-checking bench for exmem_stage_ctrl: directed scenarios plus a randomized run
// against a transaction-level model of the buffered op.
module tb_exmem_stage_ctrl;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ex_valid, ex_regwrite, ex_memwrite, ex_memtoreg, ex_branch, ex_taken;
    logic [4:0] ex_waddr, rs_a, rs_b;
    logic       uses_a, uses_b, mem_ack, wb_ready;
    logic       ex_ready, id_stall, buf_load, mem_req, wb_valid, flush, mem_err;
    logic [6:0] obs;

    int checks = 0;
    int failures = 0;

    exmem_stage_ctrl #(.REG_AW(5), .TIMEOUT(TO), .ZERO_REG(1'b1)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_ex_valid        (ex_valid),
        .o_ex_ready        (ex_ready),
        .i_ex_regwrite     (ex_regwrite),
        .i_ex_memwrite     (ex_memwrite),
        .i_ex_memtoreg     (ex_memtoreg),
        .i_ex_branch       (ex_branch),
        .i_ex_branch_taken (ex_taken),
        .i_ex_write_addr   (ex_waddr),
        .i_id_rs_a         (rs_a),
        .i_id_rs_b         (rs_b),
        .i_id_uses_a       (uses_a),
        .i_id_uses_b       (uses_b),
        .o_id_stall        (id_stall),
        .o_buf_load        (buf_load),
        .o_mem_req         (mem_req),
        .i_mem_ack         (mem_ack),
        .o_wb_valid        (wb_valid),
        .i_wb_ready        (wb_ready),
        .o_flush           (flush),
        .o_mem_err         (mem_err)
    );

    always #5 clk = ~clk;

    // Bit order: ex_ready, id_stall, buf_load, mem_req, wb_valid, flush, mem_err
    assign obs = {ex_ready, id_stall, buf_load, mem_req, wb_valid, flush, mem_err};

    task automatic set_idle;
        ex_valid = 0; ex_regwrite = 0; ex_memwrite = 0; ex_memtoreg = 0;
        ex_branch = 0; ex_taken = 0; ex_waddr = 0;
        rs_a = 0; rs_b = 0; uses_a = 0; uses_b = 0; mem_ack = 0; wb_ready = 1;
    endtask

    task automatic drive_op(input logic v, input logic rw, input logic mw, input logic mr,
                            input logic br, input logic tk, input logic [4:0] wa);
        ex_valid = v; ex_regwrite = rw; ex_memwrite = mw; ex_memtoreg = mr;
        ex_branch = br; ex_taken = tk; ex_waddr = wa;
    endtask

    task automatic do_reset;
        set_idle;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        set_idle;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if (obs !== 7'b1000000) begin
            failures++;
            $display("[TB] FAIL reset_asserted: got %b want %b", obs, 7'b1000000);
        end
        do_reset;
        #1;
        checks++;
        if (obs !== 7'b1000000) begin
            failures++;
            $display("[TB] FAIL reset_released: got %b want %b", obs, 7'b1000000);
        end
    endtask

    task automatic test_alu_latency;
        logic [6:0] want [3];
        want = '{7'b1010000, 7'b1000100, 7'b1000000};
        do_reset;
        for (int c = 0; c < 3; c++) begin
            if (c == 0) drive_op(1, 1, 0, 0, 0, 0, 5'd3);
            else        drive_op(0, 0, 0, 0, 0, 0, 5'd0);
            #1;
            checks++;
            if (obs !== want[c]) begin
                failures++;
                $display("[TB] FAIL alu_latency_c%0d: got %b want %b", c, obs, want[c]);
            end
            next_cycle;
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] want [5];
        want = '{7'b1010000, 7'b1010100, 7'b1010100, 7'b1000100, 7'b1000000};
        do_reset;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) drive_op(1, 1, 0, 0, 0, 0, 5'(c + 1));
            else       drive_op(0, 0, 0, 0, 0, 0, 5'd0);
            #1;
            checks++;
            if (obs !== want[c]) begin
                failures++;
                $display("[TB] FAIL back_to_back_c%0d: got %b want %b", c, obs, want[c]);
            end
            next_cycle;
        end
    endtask

    task automatic test_load_use;
        logic [6:0] want [7];
        logic [6:0] want0 [4];
        want  = '{7'b1010000, 7'b0101000, 7'b0101000, 7'b0101000,
                  7'b0100100, 7'b1000100, 7'b1000000};
        want0 = '{7'b1010000, 7'b0001000, 7'b1000100, 7'b1000000};
        do_reset;
        rs_a = 5'd5; uses_a = 1;
        for (int c = 0; c < 7; c++) begin
            if (c == 0) drive_op(1, 1, 0, 1, 0, 0, 5'd5);
            else        drive_op(0, 0, 0, 0, 0, 0, 5'd0);
            mem_ack  = (c == 3);
            wb_ready = (c != 4);
            #1;
            checks++;
            if (obs !== want[c]) begin
                failures++;
                $display("[TB] FAIL load_use_r5_c%0d: got %b want %b", c, obs, want[c]);
            end
            next_cycle;
        end
        rs_a = 5'd0; wb_ready = 1;
        for (int c = 0; c < 4; c++) begin
            if (c == 0) drive_op(1, 1, 0, 1, 0, 0, 5'd0);
            else        drive_op(0, 0, 0, 0, 0, 0, 5'd0);
            mem_ack = (c == 1);
            #1;
            checks++;
            if (obs !== want0[c]) begin
                failures++;
                $display("[TB] FAIL load_use_r0_c%0d: got %b want %b", c, obs, want0[c]);
            end
            next_cycle;
        end
        set_idle;
    endtask

    task automatic test_flush;
        logic [6:0] want [3];
        want = '{7'b1010000, 7'b1000110, 7'b1000000};
        do_reset;
        for (int c = 0; c < 3; c++) begin
            if (c == 0)      drive_op(1, 0, 0, 0, 1, 1, 5'd0);
            else if (c == 1) drive_op(1, 1, 0, 0, 0, 0, 5'd7);
            else             drive_op(0, 0, 0, 0, 0, 0, 5'd0);
            #1;
            checks++;
            if (obs !== want[c]) begin
                failures++;
                $display("[TB] FAIL flush_taken_c%0d: got %b want %b", c, obs, want[c]);
            end
            next_cycle;
        end
        drive_op(1, 0, 0, 0, 1, 0, 5'd0);
        #1;
        next_cycle;
        drive_op(0, 0, 0, 0, 0, 0, 5'd0);
        #1;
        checks++;
        if (obs !== 7'b1000100) begin
            failures++;
            $display("[TB] FAIL flush_not_taken: got %b want %b", obs, 7'b1000100);
        end
        next_cycle;
    endtask

    task automatic test_timeout_ack;
        logic [6:0] want;
        do_reset;
        for (int c = 0; c <= TO + 2; c++) begin
            if (c == 0) drive_op(1, 0, 1, 0, 0, 0, 5'd0);
            else        drive_op(0, 0, 0, 0, 0, 0, 5'd0);
            mem_ack = (c == TO);
            if (c == 0)           want = 7'b1010000;
            else if (c <= TO)     want = 7'b0001000;
            else if (c == TO + 1) want = 7'b1000100;
            else                  want = 7'b1000000;
            #1;
            checks++;
            if (obs !== want) begin
                failures++;
                $display("[TB] FAIL timeout_ack_c%0d: got %b want %b", c, obs, want);
            end
            next_cycle;
        end
        set_idle;
    endtask

    task automatic test_timeout_fault;
        logic [6:0] want;
        do_reset;
        for (int c = 0; c <= TO + 4; c++) begin
            if (c == 0)      drive_op(1, 0, 1, 0, 0, 0, 5'd0);
            else if (c > TO) drive_op(1, 1, 0, 0, 0, 0, 5'd2);
            else             drive_op(0, 0, 0, 0, 0, 0, 5'd0);
            mem_ack = (c > TO) && c[0];
            if (c == 0)       want = 7'b1010000;
            else if (c <= TO) want = 7'b0001000;
            else              want = 7'b0000001;
            #1;
            checks++;
            if (obs !== want) begin
                failures++;
                $display("[TB] FAIL timeout_fault_c%0d: got %b want %b", c, obs, want);
            end
            next_cycle;
        end
        set_idle;
    endtask

    task automatic test_reset_mid_wait;
        do_reset;
        drive_op(1, 0, 1, 0, 0, 0, 5'd0);
        next_cycle;
        drive_op(0, 0, 0, 0, 0, 0, 5'd0);
        #1;
        checks++;
        if (obs !== 7'b0001000) begin
            failures++;
            $display("[TB] FAIL rst_wait_pre: got %b want %b", obs, 7'b0001000);
        end
        #1 rst_n = 0;
        #1;
        checks++;
        if (obs !== 7'b1000000) begin
            failures++;
            $display("[TB] FAIL rst_wait_async: got %b want %b", obs, 7'b1000000);
        end
        mem_ack = 1;
        next_cycle;
        rst_n = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (obs !== 7'b1000000) begin
                failures++;
                $display("[TB] FAIL rst_wait_after_c%0d: got %b want %b", c, obs, 7'b1000000);
            end
            next_cycle;
        end
        set_idle;
    endtask

    // Reference: one buffered op, tracked as occupied / memory done / cycles waited.
    task automatic test_random;
        bit         m_has, m_done, m_fault, m_flush, m_isload;
        int         m_waited;
        logic [4:0] m_waddr;
        logic [6:0] want;
        bit         e_ready, e_load, e_stall, hit;
        int         kind;
        m_has = 0; m_done = 0; m_fault = 0; m_flush = 0; m_isload = 0;
        m_waited = 0; m_waddr = 0;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                do_reset;
                m_has = 0; m_done = 0; m_fault = 0; m_flush = 0; m_isload = 0;
                m_waited = 0; m_waddr = 0;
            end else begin
                next_cycle;
            end
            kind = $urandom_range(3);
            drive_op(($urandom_range(9) < 6), 1'b0, (kind == 2), (kind == 1), (kind == 3),
                     1'($urandom), 5'($urandom_range(7)));
            ex_regwrite = (kind == 1) ? 1'b1 : 1'($urandom);
            rs_a = 5'($urandom_range(7)); rs_b = 5'($urandom_range(7));
            uses_a = 1'($urandom); uses_b = 1'($urandom);
            wb_ready = ($urandom_range(9) < 7);
            mem_ack = ($urandom_range(9) < 4);
            #1;
            e_ready = !m_fault && (!m_has || (m_done && wb_ready));
            e_load  = ex_valid && e_ready && !m_flush;
            hit = (uses_a && rs_a == m_waddr) || (uses_b && rs_b == m_waddr);
            e_stall = m_has && !m_fault && m_isload && (m_waddr != 0) && hit
                      && !(m_done && wb_ready);
            want = {e_ready, e_stall, e_load, (m_has && !m_done && !m_fault),
                    (m_has && m_done && !m_fault), m_flush, m_fault};
            checks++;
            if (obs !== want) begin
                failures++;
                $display("[TB] FAIL random_i%0d: got %b want %b", i, obs, want);
            end
            if (!m_fault) begin
                if (m_has && !m_done) begin
                    if (mem_ack)                m_done = 1;
                    else if (m_waited + 1 == TO) m_fault = 1;
                    else                        m_waited++;
                end else if (m_has && m_done && wb_ready) begin
                    m_has = 0;
                end
                if (e_load) begin
                    m_has = 1;
                    m_done = !(ex_memwrite || ex_memtoreg);
                    m_waited = 0;
                    m_isload = ex_memtoreg;
                    m_waddr = ex_waddr;
                end
            end
            m_flush = e_load && ex_branch && ex_taken;
        end
        set_idle;
    endtask

    initial begin
        set_idle;
        test_reset;
        test_alu_latency;
        test_back_to_back;
        test_load_use;
        test_flush;
        test_timeout_ack;
        test_timeout_fault;
        test_reset_mid_wait;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
